// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: frame geometry,
// peripheral register map and controller state encoding.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_ctrl_timer.sv
// Loadable down-counter that stops at zero; times every fixed-length
// controller interval (setup, SCLK phases, hold, inter-frame gap).
module spi_ctrl_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 initiator: serialises {rw, addr[6:0], data[7:0]} MSB first
// with programmable SCLK half-period and nCS setup/hold/idle spacing.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  ncs,
  output logic                  copi
);

  if (CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 2) begin : g_param_chk
    $error("spi_controller: CLK_DIV>=2, CS_SETUP>=1, CS_HOLD>=1, CS_IDLE>=2 required");
  end

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W  = $clog2(MAX_P);

  // The timer reaches zero on the last cycle of an interval, so load N-1.
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] PHASE_LD = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_IDLE - 1);

  spi_state_e             state, state_nxt;
  logic [SPI_FRAME_W-1:0] frame_sh, frame_sh_nxt;
  logic [3:0]             bit_cnt, bit_cnt_nxt;
  logic                   sclk_nxt, ncs_nxt, copi_nxt, done_nxt;
  logic                   tmr_load, tmr_zero;
  logic [TMR_W-1:0]       tmr_val;

  spi_ctrl_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      copi    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sclk    <= sclk_nxt;
      ncs     <= ncs_nxt;
      copi    <= copi_nxt;
      done    <= done_nxt;
    end
  end

  // Shift data needs no reset: it is always reloaded on accept.
  always_ff @(posedge clk) begin
    frame_sh <= frame_sh_nxt;
  end

  always_comb begin
    state_nxt    = state;
    frame_sh_nxt = frame_sh;
    bit_cnt_nxt  = bit_cnt;
    sclk_nxt     = sclk;
    ncs_nxt      = ncs;
    copi_nxt     = copi;
    done_nxt     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt    = ST_SETUP;
          frame_sh_nxt = {req_rw, req_addr, req_data};
          bit_cnt_nxt  = '0;
          ncs_nxt      = 1'b0;
          sclk_nxt     = 1'b0;
          copi_nxt     = req_rw;
          tmr_load     = 1'b1;
          tmr_val      = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_nxt = ST_SHIFT_HI;
          sclk_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = PHASE_LD;
        end
      end
      ST_SHIFT_HI: begin
        if (tmr_zero) begin
          sclk_nxt = 1'b0;
          tmr_load = 1'b1;
          if (bit_cnt == 4'd15) begin
            state_nxt = ST_HOLD;
            tmr_val   = HOLD_LD;
          end else begin
            // Next bit goes out on the same edge that drops SCLK.
            state_nxt    = ST_SHIFT_LO;
            frame_sh_nxt = {frame_sh[SPI_FRAME_W-2:0], 1'b0};
            copi_nxt     = frame_sh[SPI_FRAME_W-2];
            tmr_val      = PHASE_LD;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (tmr_zero) begin
          state_nxt   = ST_SHIFT_HI;
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = bit_cnt + 4'd1;
          tmr_load    = 1'b1;
          tmr_val     = PHASE_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_nxt = ST_GAP;
          ncs_nxt   = 1'b1;
          copi_nxt  = 1'b0;
          done_nxt  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LD;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        ncs_nxt   = 1'b1;
        sclk_nxt  = 1'b0;
        copi_nxt  = 1'b0;
      end
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: two controllers (default timing and minimum timing), each
// looped back into a behavioural model of the peripheral's register file.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req_valid;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic [1:0] req_ready, busy, done, sclk, ncs, copi;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  logic [1:0]  trunc_exp;
  logic [15:0] exp_q[$];

  // Peripheral model and monitor state, indexed by DUT
  logic [7:0]  pregs[2][8];
  logic        psclk[2], pncs[2], pcopi[2];
  logic [15:0] rx_sh[2];
  logic [15:0] exp_f;
  int nb[2], low_cnt[2], last_rise[2], glitch[2], bad_per[2];
  int first_rise[2], done_cyc[2];

  always @(posedge clk) cyc <= cyc + 1;

  spi_controller u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0])
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(2)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, decodes frames at nCS rise
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mon_en) begin
        if (!ncs[g] && pncs[g]) begin
          nb[g] = 0; low_cnt[g] = 0; glitch[g] = 0; bad_per[g] = 0;
        end
        if (!ncs[g]) begin
          low_cnt[g]++;
          if (sclk[g] && copi[g] !== pcopi[g]) glitch[g]++;
          if (sclk[g] && !psclk[g]) begin
            if (nb[g] == 0) first_rise[g] = cyc;
            else if (cyc - last_rise[g] != ((g == 0) ? 8 : 4)) bad_per[g]++;
            last_rise[g] = cyc;
            rx_sh[g] = {rx_sh[g][14:0], copi[g]};
            nb[g]++;
          end
        end
        if (ncs[g] && !pncs[g]) begin
          done_cyc[g] = cyc;
          if (trunc_exp[g]) begin
            check($sformatf("trunc_bits%0d", g), nb[g], 8);
            check($sformatf("trunc_done%0d", g), done[g], 0);
            trunc_exp[g] = 1'b0;
          end else if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame%0d: got 0x%0h with no frame expected", g, rx_sh[g]);
          end else begin
            exp_f = exp_q.pop_front();
            check($sformatf("frame%0d", g), rx_sh[g], exp_f);
            check($sformatf("rise_count%0d", g), nb[g], 16);
            check($sformatf("ncs_low_cycles%0d", g), low_cnt[g], (g == 0) ? 132 : 64);
            check($sformatf("done_pulse%0d", g), done[g], 1);
            check($sformatf("copi_stable_hi%0d", g), glitch[g], 0);
            check($sformatf("sclk_period%0d", g), bad_per[g], 0);
          end
          if (nb[g] == 16 && rx_sh[g][15] && rx_sh[g][14:8] < 7'd8)
            pregs[g][rx_sh[g][10:8]] = rx_sh[g][7:0];
        end
      end
      psclk[g] = sclk[g];
      pncs[g]  = ncs[g];
      pcopi[g] = copi[g];
    end
  end

  task automatic send(input int g, input logic [15:0] f, input bit push, output int acc);
    int n = 0;
    @(negedge clk);
    req_rw = f[15]; req_addr = f[14:8]; req_data = f[7:0];
    req_valid[g] = 1'b1;
    while (!req_ready[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: ready still 0 after %0d cycles", g, n);
    end
    acc = cyc;
    if (push) exp_q.push_back(f);
    @(posedge clk);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((!req_ready[g] || exp_q.size() != 0) && n < 3000);
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL idle_timeout%0d: still busy after %0d cycles", g, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n, rises;
    logic prev;
    rst = 1'b1; req_valid = '0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    trunc_exp = '0;
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 8; r++) pregs[g][r] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_ncs", ncs[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_copi", copi[0], 0);
    check("rst_done", done[0], 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single write 0x80A5
    send(0, 16'h80A5, 1'b1, acc);
    @(negedge clk);
    req_valid = '0;
    check("accept_ncs", ncs[0], 0);
    check("accept_busy", busy[0], 1);
    check("accept_ready", req_ready[0], 0);
    wait_idle(0);
    check("first_rise_time", first_rise[0] - acc, 5);
    check("done_time", done_cyc[0] - acc, 133);
    check("reg_en_out_7_0", pregs[0][ADDR_EN_OUT_7_0[2:0]], 8'hA5);

    // Back-to-back with req_valid held
    send(0, 16'h8480, 1'b1, acc);
    send(0, 16'h820F, 1'b1, acc2);
    @(negedge clk);
    req_valid = '0;
    check("b2b_accept_gap", acc2 - acc, 137);
    check("b2b_ncs_high_to_accept", acc2 - done_cyc[0], 4);
    wait_idle(0);
    check("reg_pwm_duty", pregs[0][ADDR_PWM_DUTY[2:0]], 8'h80);
    check("reg_en_pwm_7_0", pregs[0][ADDR_EN_PWM_7_0[2:0]], 8'h0F);

    // Request fields churn while busy
    send(0, 16'h8133, 1'b1, acc);
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 3000) begin
      req_rw = n[0]; req_addr = 7'(n * 3); req_data = 8'(~n);
      n++;
      @(negedge clk);
    end
    req_valid = '0;
    check("ready_low_cycles", n, 136);
    wait_idle(0);
    check("reg_en_out_15_8_a", pregs[0][ADDR_EN_OUT_15_8[2:0]], 8'h33);

    // Reset after the 8th SCLK rise
    trunc_exp[0] = 1'b1;
    send(0, 16'h8155, 1'b0, acc);
    @(negedge clk);
    req_valid = '0;
    rises = 0; n = 0; prev = sclk[0];
    while (rises < 8 && n < 2000) begin
      @(negedge clk);
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ncs", ncs[0], 1);
    check("midrst_sclk", sclk[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", req_ready[0], 1);
    wait_idle(0);
    check("reg_en_out_15_8_kept", pregs[0][ADDR_EN_OUT_15_8[2:0]], 8'h33);
    send(0, 16'h8155, 1'b1, acc);
    @(negedge clk);
    req_valid = '0;
    wait_idle(0);
    check("reg_en_out_15_8_b", pregs[0][ADDR_EN_OUT_15_8[2:0]], 8'h55);

    // Read frame does not write
    send(0, 16'h0477, 1'b1, acc);
    @(negedge clk);
    req_valid = '0;
    wait_idle(0);
    check("read_no_write", pregs[0][ADDR_PWM_DUTY[2:0]], 8'h80);

    // Minimum timing instance
    send(1, 16'h8301, 1'b1, acc);
    @(negedge clk);
    req_valid = '0;
    wait_idle(1);
    check("min_first_rise_time", first_rise[1] - acc, 2);
    check("min_done_time", done_cyc[1] - acc, 65);
    check("min_reg_en_pwm_15_8", pregs[1][ADDR_EN_PWM_15_8[2:0]], 8'h01);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
